// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide base types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/request_unit_pkg.sv
// Types and default widths for the round-robin request unit.
// The optional watchdog is enabled with REQUEST_UNIT_TIMEOUT_EN.
package request_unit_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } ru_state_t;

  localparam int RU_AW = $bits(word_t);
  localparam int RU_DW = $bits(word_t);
endpackage

// File: rtl/request_unit_rr_if.sv
// Companion bundle for request_unit_rr: ru = unit side, tb = requester/memory side.
interface request_unit_rr_if #(
  parameter int N_CH = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input logic CLK
);
  logic                     RST;
  logic [N_CH-1:0]          req_ren;
  logic [N_CH-1:0]          req_wen;
  logic [N_CH-1:0][AW-1:0]  req_addr;
  logic [N_CH-1:0][DW-1:0]  req_wdata;
  logic [N_CH-1:0]          resp_valid;
  logic [DW-1:0]            resp_rdata;
  logic                     resp_err;
  logic                     mem_ren;
  logic                     mem_wen;
  logic [AW-1:0]            mem_addr;
  logic [DW-1:0]            mem_wdata;
  logic                     mem_hit;
  logic [DW-1:0]            mem_rdata;
  logic                     busy;
  logic                     timeout;

  modport ru (
    input  CLK, RST, req_ren, req_wen, req_addr, req_wdata, mem_hit, mem_rdata,
    output resp_valid, resp_rdata, resp_err, mem_ren, mem_wen, mem_addr, mem_wdata,
           busy, timeout
  );
  modport tb (
    input  CLK, resp_valid, resp_rdata, resp_err, mem_ren, mem_wen, mem_addr, mem_wdata,
           busy, timeout,
    output RST, req_ren, req_wen, req_addr, req_wdata, mem_hit, mem_rdata
  );
endinterface

// File: rtl/ru_rr_arbiter.sv
// Combinational round-robin pick: first active channel after i_last, wrapping.
module ru_rr_arbiter #(
  parameter int N_CH = 2,
  parameter int LW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] i_active,
  input  logic [LW-1:0]   i_last,
  output logic [LW-1:0]   o_grant,
  output logic            o_any
);
  // Scan farthest-to-nearest so the nearest active channel is the final assignment.
  always_comb begin
    logic [LW-1:0] idx;
    o_grant = i_last;
    for (int k = N_CH; k >= 1; k--) begin
      idx = LW'((int'(i_last) + k) % N_CH);
      if (i_active[idx]) o_grant = idx;
    end
  end

  assign o_any = |i_active;
endmodule

// File: rtl/request_unit_rr.sv
// Round-robin arbitrated front end holding one request on the memory port until mem_hit.
// Define REQUEST_UNIT_TIMEOUT_EN to add the abort watchdog (resp_err / sticky timeout).
module request_unit_rr
  import request_unit_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int AW      = RU_AW,
  parameter int DW      = RU_DW,
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_CH-1:0]         req_ren,
  input  logic [N_CH-1:0]         req_wen,
  input  logic [N_CH-1:0][AW-1:0] req_addr,
  input  logic [N_CH-1:0][DW-1:0] req_wdata,
  output logic [N_CH-1:0]         resp_valid,
  output logic [DW-1:0]           resp_rdata,
  output logic                    resp_err,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic                    mem_hit,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    busy,
  output logic                    timeout
);
  localparam int LW = $clog2(N_CH);

  if (N_CH < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("request_unit_rr: N_CH must be >= 2 and TIMEOUT >= 1");
  end

  ru_state_t        r_state;
  logic [LW-1:0]    r_grant, r_last;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata, r_rdata;
  logic             r_is_wr, r_mem_ren, r_mem_wen;
  logic [N_CH-1:0]  r_resp_valid;
  logic [N_CH-1:0]  w_active;
  logic [LW-1:0]    w_grant;
  logic             w_any;

  assign w_active = req_ren | req_wen;

  ru_rr_arbiter #(.N_CH(N_CH), .LW(LW)) u_arb (
    .i_active (w_active),
    .i_last   (r_last),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

`ifdef REQUEST_UNIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err, r_timeout;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last       <= LW'(N_CH - 1);
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_is_wr      <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_resp_valid <= '0;
`ifdef REQUEST_UNIT_TIMEOUT_EN
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_resp_valid <= '0;
`ifdef REQUEST_UNIT_TIMEOUT_EN
      r_err        <= 1'b0;
`endif
      case (r_state)
        IDLE: if (w_any) begin
          r_state   <= REQ;
          r_grant   <= w_grant;
          r_addr    <= req_addr[w_grant];
          r_wdata   <= req_wdata[w_grant];
          r_is_wr   <= req_wen[w_grant];
          r_mem_ren <= ~req_wen[w_grant];
          r_mem_wen <= req_wen[w_grant];
`ifdef REQUEST_UNIT_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        REQ: if (mem_hit) begin
          // Write responses keep the previous read data visible.
          if (!r_is_wr) r_rdata <= mem_rdata;
          r_last                <= r_grant;
          r_state               <= DONE;
          r_mem_ren             <= 1'b0;
          r_mem_wen             <= 1'b0;
          r_resp_valid[r_grant] <= 1'b1;
        end
`ifdef REQUEST_UNIT_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          // Rotate past the aborted channel so a dead target cannot starve the others.
          r_last                <= r_grant;
          r_state               <= DONE;
          r_mem_ren             <= 1'b0;
          r_mem_wen             <= 1'b0;
          r_resp_valid[r_grant] <= 1'b1;
          r_err                 <= 1'b1;
          r_timeout             <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign mem_ren    = r_mem_ren;
  assign mem_wen    = r_mem_wen;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = (r_state != IDLE);
`ifdef REQUEST_UNIT_TIMEOUT_EN
  assign resp_err   = r_err;
  assign timeout    = r_timeout;
`else
  assign resp_err   = 1'b0;
  assign timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_request_unit_rr.sv
// Directed bench for request_unit_rr (N_CH=2, TIMEOUT=4); watchdog cases under REQUEST_UNIT_TIMEOUT_EN.
module tb_request_unit_rr;
  logic                 CLK, RST;
  logic [1:0]           req_ren, req_wen;
  logic [1:0][31:0]     req_addr, req_wdata;
  logic [1:0]           resp_valid;
  logic [31:0]          resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic                 resp_err, mem_ren, mem_wen, mem_hit, busy, timeout;
  int                   pass_cnt = 0;
  int                   total    = 0;

  request_unit_rr #(.N_CH(2), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_hit(mem_hit), .mem_rdata(mem_rdata), .busy(busy), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic clear_inputs;
    req_ren = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    mem_hit = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    RST = 1'b0;
    #2 RST = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if ({mem_ren, mem_wen} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {mem_ren, mem_wen}); else pass_cnt++;
    total++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", resp_valid); else pass_cnt++;
    total++; if ({mem_addr, mem_wdata, resp_rdata} !== 96'h0) $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, resp_rdata}); else pass_cnt++;
    total++; if ({timeout, resp_err} !== 2'b00) $display("FAIL reset_timeout: got %b want 00", {timeout, resp_err}); else pass_cnt++;
    tick(); RST = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    req_ren = 2'b01; req_addr[0] = 32'h0000_0040;
    tick();
    total++; if ({busy, mem_ren, mem_wen} !== 3'b110) $display("FAIL single_req1: got %b want 110", {busy, mem_ren, mem_wen}); else pass_cnt++;
    total++; if (mem_addr !== 32'h40) $display("FAIL single_addr: got %h want 00000040", mem_addr); else pass_cnt++;
    tick();
    total++; if ({mem_ren, resp_valid} !== 3'b100) $display("FAIL single_req2: got %b want 100", {mem_ren, resp_valid}); else pass_cnt++;
    mem_hit = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    total++; if (resp_valid !== 2'b01) $display("FAIL single_resp_valid: got %b want 01", resp_valid); else pass_cnt++;
    total++; if (resp_rdata !== 32'hDEAD_BEEF) $display("FAIL single_rdata: got %h want deadbeef", resp_rdata); else pass_cnt++;
    total++; if (mem_ren !== 1'b0) $display("FAIL single_done_strobe: got %b want 0", mem_ren); else pass_cnt++;
    req_ren = 2'b00; mem_hit = 1'b0; mem_rdata = 32'h0;
    tick();
    total++; if ({busy, resp_valid} !== 3'b000) $display("FAIL single_idle: got %b want 000", {busy, resp_valid}); else pass_cnt++;
    total++; if (resp_rdata !== 32'hDEAD_BEEF) $display("FAIL single_rdata_hold: got %h want deadbeef", resp_rdata); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_addr;
    logic [1:0]  exp_v;
    do_reset();
    req_ren = 2'b11; req_addr[0] = 32'h40; req_addr[1] = 32'h80; mem_hit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 1) ? 32'h80 : 32'h40;
      exp_v    = (i % 2 == 1) ? 2'b10 : 2'b01;
      mem_rdata = 32'h1000 + i;
      tick();
      total++; if ({mem_ren, mem_addr} !== {1'b1, exp_addr}) $display("FAIL rr_grant%0d: got %h want %h", i, {mem_ren, mem_addr}, {1'b1, exp_addr}); else pass_cnt++;
      tick();
      total++; if (resp_valid !== exp_v) $display("FAIL rr_resp%0d: got %b want %b", i, resp_valid, exp_v); else pass_cnt++;
      total++; if (resp_rdata !== 32'h1000 + i) $display("FAIL rr_rdata%0d: got %h want %h", i, resp_rdata, 32'h1000 + i); else pass_cnt++;
      tick();
      total++; if ({busy, resp_valid} !== 3'b000) $display("FAIL rr_idle%0d: got %b want 000", i, {busy, resp_valid}); else pass_cnt++;
    end
    req_ren = 2'b00; mem_hit = 1'b0;
  endtask

  task automatic test_write_priority;
    req_ren = 2'b10; req_wen = 2'b10; req_addr[1] = 32'h100; req_wdata[1] = 32'h1234;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    total++; if ({mem_wen, mem_ren} !== 2'b10) $display("FAIL wr_strobes: got %b want 10", {mem_wen, mem_ren}); else pass_cnt++;
    total++; if ({mem_addr, mem_wdata} !== {32'h100, 32'h1234}) $display("FAIL wr_addr_data: got %h want %h", {mem_addr, mem_wdata}, {32'h100, 32'h1234}); else pass_cnt++;
    mem_hit = 1'b1;
    tick();
    total++; if (resp_valid !== 2'b10) $display("FAIL wr_resp: got %b want 10", resp_valid); else pass_cnt++;
    total++; if (resp_rdata !== 32'h1003) $display("FAIL wr_rdata_hold: got %h want 00001003", resp_rdata); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_addr_hold;
    req_ren = 2'b01; req_addr[0] = 32'h40;
    tick();
    total++; if (mem_addr !== 32'h40) $display("FAIL hold_addr1: got %h want 00000040", mem_addr); else pass_cnt++;
    req_addr[0] = 32'h80;
    tick();
    total++; if (mem_addr !== 32'h40) $display("FAIL hold_addr2: got %h want 00000040", mem_addr); else pass_cnt++;
    mem_hit = 1'b1; mem_rdata = 32'h55;
    tick();
    total++; if ({resp_valid, mem_addr} !== {2'b01, 32'h40}) $display("FAIL hold_done: got %h want %h", {resp_valid, mem_addr}, {2'b01, 32'h40}); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

`ifdef REQUEST_UNIT_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    req_ren = 2'b01; req_addr[0] = 32'h40;
    tick();
    for (int j = 1; j <= 4; j++) begin
      total++; if ({busy, mem_ren, resp_valid} !== 4'b1100) $display("FAIL to_wait%0d: got %b want 1100", j, {busy, mem_ren, resp_valid}); else pass_cnt++;
      tick();
    end
    total++; if ({resp_valid, resp_err, timeout} !== 4'b0111) $display("FAIL to_abort: got %b want 0111", {resp_valid, resp_err, timeout}); else pass_cnt++;
    total++; if (resp_rdata !== 32'h0) $display("FAIL to_rdata: got %h want 00000000", resp_rdata); else pass_cnt++;
    req_ren = 2'b00;
    tick();
    total++; if ({busy, resp_err, timeout} !== 3'b001) $display("FAIL to_sticky: got %b want 001", {busy, resp_err, timeout}); else pass_cnt++;
    req_ren = 2'b01;
    tick();
    for (int j = 1; j <= 3; j++) tick();
    mem_hit = 1'b1; mem_rdata = 32'hCAFE;
    tick();
    total++; if ({resp_valid, resp_err} !== 3'b010) $display("FAIL to_hit_wins: got %b want 010", {resp_valid, resp_err}); else pass_cnt++;
    total++; if (resp_rdata !== 32'hCAFE) $display("FAIL to_hit_rdata: got %h want 0000cafe", resp_rdata); else pass_cnt++;
    clear_inputs();
    tick();
  endtask
`else
  task automatic test_no_timeout;
    do_reset();
    req_ren = 2'b01; req_addr[0] = 32'h40;
    tick();
    for (int j = 0; j < 8; j++) tick();
    total++; if ({busy, mem_ren, resp_valid} !== 4'b1100) $display("FAIL nto_wait: got %b want 1100", {busy, mem_ren, resp_valid}); else pass_cnt++;
    total++; if ({resp_err, timeout} !== 2'b00) $display("FAIL nto_flags: got %b want 00", {resp_err, timeout}); else pass_cnt++;
    mem_hit = 1'b1; mem_rdata = 32'h77;
    tick();
    total++; if ({resp_valid, resp_err} !== 3'b010) $display("FAIL nto_done: got %b want 010", {resp_valid, resp_err}); else pass_cnt++;
    clear_inputs();
    tick();
  endtask
`endif

  task automatic test_reset_mid_req;
    req_ren = 2'b10; req_addr[0] = 32'h40; req_addr[1] = 32'h80;
    tick();
    total++; if ({mem_ren, mem_addr} !== {1'b1, 32'h80}) $display("FAIL rst_pre: got %h want %h", {mem_ren, mem_addr}, {1'b1, 32'h80}); else pass_cnt++;
    #2 RST = 1'b1;
    #1;
    total++; if ({busy, mem_ren, mem_wen, resp_valid} !== 5'b0) $display("FAIL rst_async: got %b want 00000", {busy, mem_ren, mem_wen, resp_valid}); else pass_cnt++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 00000000", mem_addr); else pass_cnt++;
    req_ren = 2'b11; mem_hit = 1'b1;
    tick();
    total++; if ({busy, mem_ren, resp_valid} !== 4'b0) $display("FAIL rst_held: got %b want 0000", {busy, mem_ren, resp_valid}); else pass_cnt++;
    RST = 1'b0; mem_hit = 1'b0;
    tick();
    total++; if ({mem_ren, mem_addr} !== {1'b1, 32'h40}) $display("FAIL rst_first_grant: got %h want %h", {mem_ren, mem_addr}, {1'b1, 32'h40}); else pass_cnt++;
    mem_hit = 1'b1;
    tick();
    total++; if (resp_valid !== 2'b01) $display("FAIL rst_resp: got %b want 01", resp_valid); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_addr_hold();
`ifdef REQUEST_UNIT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_req();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
